imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_pkg.sv | 5 +
 rtl/imem_loader_if.sv | 11 +
 rtl/imem_loader_assembler.sv | 31 +++
 rtl/imem_loader.sv | 95 +++++++++
 tb/tb_imem_loader.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: loader state encoding and the restart PC shared with the fetch stage
package imem_loader_pkg;
    typedef enum logic [2:0] {IDLE, HDR0, HDR1, DATA, CHECK, DONE, ERR} ld_state_t;
    localparam logic [18:0] PC_RESET = 19'h0;
endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream handshake plus instruction-memory write port
interface imem_loader_if #(parameter int AWID = 10);
    logic            byte_valid_i;
    logic [7:0]      byte_i;
    logic            byte_ready_o;
    logic            mem_wr_o;
    logic [AWID-1:0] mem_addr_o;
    logic [31:0]     mem_wdata_o;
    modport master (input byte_valid_i, byte_i, output byte_ready_o, mem_wr_o, mem_addr_o, mem_wdata_o);
    modport slave (output byte_valid_i, byte_i, input byte_ready_o, mem_wr_o, mem_addr_o, mem_wdata_o);
endinterface

// File: rtl/imem_loader_assembler.sv
// imem_loader_assembler: byte index, little-endian word assembly and XOR checksum
module imem_loader_assembler (
    input  logic        clk,
    input  logic        resetn,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  byte_in,
    output logic        last,
    output logic [31:0] word,
    output logic [7:0]  csum
);
    logic [1:0]  idx;
    logic [23:0] acc;
    assign last = idx == 2'd3;
    assign word = {byte_in, acc};
    // bytes enter at the top and shift down, so byte 0 lands in bits [7:0]
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            idx  <= '0;
            acc  <= '0;
            csum <= '0;
        end else if (clr) begin
            idx  <= '0;
            acc  <= '0;
            csum <= '0;
        end else if (en) begin
            idx  <= idx + 2'd1;
            acc  <= {byte_in, acc[23:8]};
            csum <= csum ^ byte_in;
        end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot loader streaming a counted, checksummed image into instruction memory
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int AWID = 10,
    parameter int TOW  = 16
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start_i,
    imem_loader_if.master        bus,
    output logic                 cpu_hold_o,
    output logic                 wr_pc_o,
    output logic [18:0]          pc_o,
    output logic                 done_o,
    output logic                 err_o
);
    ld_state_t       state;
    logic [15:0]     n;
    logic [AWID-1:0] addr;
    logic [TOW-1:0]  to;
    logic            active, xfer, last, oversize;
    logic [15:0]     n_full;
    logic [31:0]     word;
    logic [7:0]      csum;
    assign active = state inside {HDR0, HDR1, DATA, CHECK};
    assign xfer = bus.byte_valid_i & bus.byte_ready_o;
    assign n_full = {bus.byte_i, n[7:0]};
    assign oversize = {1'b0, n_full} > (17'd1 << AWID);
    assign bus.byte_ready_o = active;
    assign cpu_hold_o = state != DONE;
    assign done_o = state == DONE;
    assign err_o = state == ERR;
    assign pc_o = PC_RESET;
    imem_loader_assembler u_asm (
        .clk     (clk),
        .resetn  (resetn),
        .clr     (!active && start_i),
        .en      (xfer && state == DATA),
        .byte_in (bus.byte_i),
        .last    (last),
        .word    (word),
        .csum    (csum)
    );
    // load sequencer: header, data words, checksum, with an inter-byte watchdog
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            state           <= IDLE;
            n               <= '0;
            addr            <= '0;
            to              <= '0;
            bus.mem_wr_o    <= 1'b0;
            bus.mem_addr_o  <= '0;
            bus.mem_wdata_o <= '0;
            wr_pc_o         <= 1'b0;
        end else begin
            bus.mem_wr_o <= 1'b0;
            wr_pc_o      <= 1'b0;
            if (!active) begin
                to <= '0;
                if (start_i) begin
                    state <= HDR0;
                    addr  <= '0;
                end
            end else if (!xfer) begin
                if (to == ~TOW'(1)) state <= ERR;
                else to <= to + 1'b1;
            end else begin
                to <= '0;
                case (state)
                    HDR0: begin
                        n[7:0] <= bus.byte_i;
                        state  <= HDR1;
                    end
                    HDR1: begin
                        n[15:8] <= bus.byte_i;
                        state   <= n_full == 16'd0 ? CHECK : oversize ? ERR : DATA;
                    end
                    DATA: if (last) begin
                        bus.mem_wr_o    <= 1'b1;
                        bus.mem_addr_o  <= addr;
                        bus.mem_wdata_o <= word;
                        addr            <= addr + 1'b1;
                        n               <= n - 16'd1;
                        if (n == 16'd1) state <= CHECK;
                    end
                    CHECK: begin
                        state   <= bus.byte_i == csum ? DONE : ERR;
                        wr_pc_o <= bus.byte_i == csum;
                    end
                    default: ;
                endcase
            end
        end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed vectors for imem_loader with hand-computed expectations
module tb_imem_loader;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start_i = 1'b0;
    logic        cpu_hold_o, wr_pc_o, done_o, err_o;
    logic [18:0] pc_o;
    int          n_chk = 0;
    int          n_fail = 0;
    logic [3:0]  wa[$];
    logic [31:0] wd[$];
    int          pc_cnt = 0;
    logic [18:0] pc_seen = '1;
    logic        hold_seen = 1'b1;

    imem_loader_if #(.AWID(4)) bus ();

    imem_loader #(.AWID(4), .TOW(4)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start_i    (start_i),
        .bus        (bus),
        .cpu_hold_o (cpu_hold_o),
        .wr_pc_o    (wr_pc_o),
        .pc_o       (pc_o),
        .done_o     (done_o),
        .err_o      (err_o)
    );

    always #5 clk = ~clk;

    // record memory writes and PC pulses away from the active edge
    always @(negedge clk) begin
        if (bus.mem_wr_o) begin
            wa.push_back(bus.mem_addr_o);
            wd.push_back(bus.mem_wdata_o);
        end
        if (wr_pc_o) begin
            pc_cnt    = pc_cnt + 1;
            pc_seen   = pc_o;
            hold_seen = cpu_hold_o;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon;
        wa.delete();
        wd.delete();
        pc_cnt = 0;
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        bus.byte_valid_i = 1'b1;
        bus.byte_i = b;
    endtask

    task automatic gap(input int k);
        @(negedge clk);
        bus.byte_valid_i = 1'b0;
        repeat (k - 1) @(negedge clk);
    endtask

    task automatic pulse_start;
        clear_mon();
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_ready"}, 32'(bus.byte_ready_o), 32'd0);
        check({tag, "_wr"}, 32'(bus.mem_wr_o), 32'd0);
        check({tag, "_addr"}, 32'(bus.mem_addr_o), 32'd0);
        check({tag, "_wdata"}, bus.mem_wdata_o, 32'd0);
        check({tag, "_hold"}, 32'(cpu_hold_o), 32'd1);
        check({tag, "_wrpc"}, 32'(wr_pc_o), 32'd0);
        check({tag, "_done"}, 32'(done_o), 32'd0);
        check({tag, "_err"}, 32'(err_o), 32'd0);
    endtask

    function automatic logic [31:0] wa_at(input int i);
        return i < wa.size() ? 32'(wa[i]) : 32'hxxxxxxxx;
    endfunction

    function automatic logic [31:0] wd_at(input int i);
        return i < wd.size() ? wd[i] : 32'hxxxxxxxx;
    endfunction

    initial begin
        bus.byte_valid_i = 1'b0;
        bus.byte_i = 8'h00;
        repeat (3) @(negedge clk);
        check_reset("rst");
        resetn = 1'b1;

        // nominal two-word load, checksum 13^6F = 7C
        pulse_start();
        check("nom_ready", 32'(bus.byte_ready_o), 32'd1);
        check("nom_hold_busy", 32'(cpu_hold_o), 32'd1);
        send(8'h02); send(8'h00);
        send(8'h13); send(8'h00); send(8'h00); send(8'h00);
        send(8'h6F); send(8'h00); send(8'h00); send(8'h00);
        send(8'h7C);
        gap(2);
        check("nom_nwr", 32'(wa.size()), 32'd2);
        check("nom_a0", wa_at(0), 32'd0);
        check("nom_d0", wd_at(0), 32'h00000013);
        check("nom_a1", wa_at(1), 32'd1);
        check("nom_d1", wd_at(1), 32'h0000006F);
        check("nom_done", 32'(done_o), 32'd1);
        check("nom_err", 32'(err_o), 32'd0);
        check("nom_hold", 32'(cpu_hold_o), 32'd0);
        check("nom_pccnt", 32'(pc_cnt), 32'd1);
        check("nom_pc", 32'(pc_seen), 32'd0);
        check("nom_hold_at_pc", 32'(hold_seen), 32'd0);
        check("nom_ready_done", 32'(bus.byte_ready_o), 32'd0);
        gap(5);
        check("nom_done_sticky", 32'(done_o), 32'd1);

        // same load with a wrong checksum byte
        pulse_start();
        check("bad_done_clr", 32'(done_o), 32'd0);
        send(8'h02); send(8'h00);
        send(8'h13); send(8'h00); send(8'h00); send(8'h00);
        send(8'h6F); send(8'h00); send(8'h00); send(8'h00);
        send(8'h00);
        gap(2);
        check("bad_err", 32'(err_o), 32'd1);
        check("bad_done", 32'(done_o), 32'd0);
        check("bad_hold", 32'(cpu_hold_o), 32'd1);
        check("bad_pccnt", 32'(pc_cnt), 32'd0);
        check("bad_nwr", 32'(wa.size()), 32'd2);

        // empty image
        pulse_start();
        check("n0_err_clr", 32'(err_o), 32'd0);
        send(8'h00); send(8'h00); send(8'h00);
        gap(2);
        check("n0_nwr", 32'(wa.size()), 32'd0);
        check("n0_done", 32'(done_o), 32'd1);
        check("n0_pccnt", 32'(pc_cnt), 32'd1);

        // 17 words do not fit a 16-word memory
        pulse_start();
        send(8'h11); send(8'h00);
        gap(1);
        check("ovr_err", 32'(err_o), 32'd1);
        check("ovr_ready", 32'(bus.byte_ready_o), 32'd0);
        gap(4);
        check("ovr_nwr", 32'(wa.size()), 32'd0);

        // 14-cycle stall inside a word is tolerated; checksum AA^BB^CC^DD = 00
        pulse_start();
        send(8'h01); send(8'h00);
        send(8'hAA);
        gap(14);
        send(8'hBB); send(8'hCC); send(8'hDD);
        send(8'h00);
        gap(2);
        check("gap14_err", 32'(err_o), 32'd0);
        check("gap14_done", 32'(done_o), 32'd1);
        check("gap14_nwr", 32'(wa.size()), 32'd1);
        check("gap14_d0", wd_at(0), 32'hDDCCBBAA);

        // 15-cycle stall trips the watchdog
        pulse_start();
        send(8'h01); send(8'h00);
        send(8'hAA);
        gap(14);
        check("to14_err", 32'(err_o), 32'd0);
        gap(1);
        @(negedge clk);
        check("to15_err", 32'(err_o), 32'd1);
        check("to15_hold", 32'(cpu_hold_o), 32'd1);
        check("to15_nwr", 32'(wa.size()), 32'd0);

        // reset in the middle of DATA, then a clean one-word load
        pulse_start();
        send(8'h02); send(8'h00);
        send(8'h11); send(8'h22); send(8'h33);
        @(negedge clk);
        bus.byte_valid_i = 1'b0;
        resetn = 1'b0;
        #1;
        check_reset("mid");
        @(negedge clk);
        resetn = 1'b1;
        gap(3);
        check("mid_nwr", 32'(wa.size()), 32'd0);
        pulse_start();
        send(8'h01); send(8'h00);
        send(8'h44); send(8'h33); send(8'h22); send(8'h11);
        send(8'h44);
        gap(2);
        check("rl_nwr", 32'(wa.size()), 32'd1);
        check("rl_a0", wa_at(0), 32'd0);
        check("rl_d0", wd_at(0), 32'h11223344);
        check("rl_done", 32'(done_o), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
